fifo_rd_unpacker: RTL
=====================

Name: fifo_rd_unpacker

Overview:
- Downstream consumer of the synchronous show-ahead FIFO: pops one IN_WIDTH word at a time and serialises it into RATIO = IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream.
- Owns the FIFO's rden; runs at full throughput, so a new word is popped in the same cycle the last beat of the previous word is accepted.
- Stream outputs come from flops, with only a beat-select mux after them.

Parameters:
- IN_WIDTH, 32, FIFO word width; must equal the FIFO's FIFO_WIDTH.
- OUT_WIDTH, 8, output beat width; IN_WIDTH % OUT_WIDTH == 0 required, with an elaboration-time $error otherwise.
- MSB_FIRST, 1'b0, 0: beat 0 = bits [OUT_WIDTH-1:0]; 1: beat 0 = most-significant slice.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- fifo_empty  input  1  FIFO empty flag; fifo_rddata is valid when low
- fifo_rddata  input  IN_WIDTH  FIFO head word (show-ahead, combinational)
- fifo_rden  output  1  pop strobe to FIFO (combinational)
- flush  input  1  synchronous discard of the partially sent word
- m_valid  output  1  beat valid
- m_ready  input  1  downstream accepts beat
- m_data  output  OUT_WIDTH  beat data
- m_last  output  1  high on final beat of a word
- busy  output  1  holding register loaded (equals m_valid)

Behaviour:
- State:
  - word_q[IN_WIDTH-1:0]
  - loaded (1 bit)
  - idx[$clog2(RATIO)-1:0]; for RATIO=1, idx is a 1-bit constant 0.
- Two states:
  - EMPTY (loaded=0)
  - ACTIVE (loaded=1)
- Reset (async): loaded=0, idx=0, word_q=0. Outputs during and after reset: m_valid=0, m_last=0, m_data=0, busy=0. fifo_rden is gated with rstn, so it is 0 while reset is asserted.
- Handshake and pop:
  - acc = m_valid & m_ready; last = (idx == RATIO-1); fin = acc & last.
  - fifo_rden = rstn & !flush & !fifo_empty & (!loaded | fin).
- On fifo_rden: word_q <= fifo_rddata, loaded <= 1, idx <= 0.
- Else, on fin: loaded <= 0, idx <= 0.
- Else, on acc: idx <= idx + 1, which never wraps past RATIO-1.
- m_valid = loaded.
- m_data = word_q slice[idx] (MSB_FIRST selects the slice order).
- m_last = loaded & last.
- Latency: a word present at the FIFO head (fifo_empty=0) in cycle N while EMPTY is popped at the edge ending N; beat 0 is valid in N+1.
- Throughput: with m_ready held high, one beat per cycle and no bubble between words.
- Backpressure: while m_valid=1 and m_ready=0, m_data, m_last and idx hold stable and fifo_rden=0. Valid is never dropped without a handshake except by flush or reset.
- fifo_empty=1 at fin: go to EMPTY and wait; m_valid is 0 the next cycle.
- flush=1: has priority over all other events.
  - Next cycle loaded=0 and idx=0.
  - The beat presented in the flush cycle is treated as not accepted, even if m_ready=1.
  - fifo_rden=0 in the flush cycle, so FIFO contents are untouched.
- Reset mid-word: the partial word is lost and all state clears immediately.
- The block never pops while the FIFO reports empty; the FIFO's own full/empty guarding is not relied upon.

Decomposition:
- A shared package fifo_pkg holds:
  - a function ratio_f(in_w, out_w) returning in_w/out_w;
  - a function idx_w_f(ratio) returning max(1, $clog2(ratio)).
- One sub-module is natural: beat_slice_mux, a parameterised slice selector for word_q, idx and MSB_FIRST to m_data.
- Everything else stays in the top module.

Test Plan:
1. Defaults; FIFO holds 0xDDCCBBAA; m_ready=1 → fifo_rden pulses once, then 4 consecutive beats AA, BB, CC, DD; m_last only on DD; m_valid low afterwards.
2. Two words 0x44332211 and 0x88776655 queued; m_ready=1 → 8 back-to-back beats 11..88 with no gap; fifo_rden high exactly in the cycles of beat "pre-load" and beat 44 (fin).
3. Backpressure: m_ready=0 for 3 cycles during beat BB → m_data=BB held, idx unchanged, fifo_rden=0; release → CC follows next.
4. MSB_FIRST=1, word 0xDDCCBBAA → beats DD, CC, BB, AA.
5. flush asserted on beat BB with m_ready=1 → next cycle m_valid=0; next FIFO word 0x55667788 then emits 88 first; the FIFO count decrements only for popped words.
6. rstn pulsed low mid-word (after beat AA) → m_valid=0, fifo_rden=0 during reset; after release with the FIFO empty, m_valid stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO read-side unpacker: beat ratio, index width and the FSM encoding.
package fifo_pkg;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_ACTIVE = 1'b1
    } unpack_state_e;

    function automatic int unsigned ratio_f(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    // Beat index is at least one bit wide so RATIO=1 still has a (constant-zero) index.
    function automatic int unsigned idx_w_f(input int unsigned ratio);
        int unsigned w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_rd_unpacker_beat_slice_mux.sv
// Selects the OUT_WIDTH slice of a held word addressed by the beat index.
module beat_slice_mux #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 8,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [IN_WIDTH-1:0]  word,
    input  logic [IDX_W-1:0]     idx,
    output logic [OUT_WIDTH-1:0] data
);
    localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;

    // OR-chain of one-hot-masked slices keeps every select index a constant.
    logic [RATIO:0][OUT_WIDTH-1:0] chain;

    assign chain[0] = '0;

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        localparam int unsigned SRC = MSB_FIRST ? (RATIO - 1 - g) : g;
        logic hit;
        assign hit          = (idx == IDX_W'(g));
        assign chain[g + 1] = chain[g] | (hit ? word[SRC*OUT_WIDTH +: OUT_WIDTH] : '0);
    end

    assign data = chain[RATIO];

endmodule

// File: rtl/fifo_rd_unpacker.sv
// Pops words from a show-ahead FIFO and streams them out as RATIO narrow valid/ready beats.
module fifo_rd_unpacker
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_rddata,
    output logic                 fifo_rden,
    input  logic                 flush,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 busy
);
    localparam int unsigned      RATIO    = ratio_f(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned      IDX_W    = idx_w_f(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_width_check
        $error("fifo_rd_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH");
    end

    unpack_state_e       state_q;
    logic [IN_WIDTH-1:0] word_q;
    logic [IDX_W-1:0]    idx_q;

    logic loaded;
    logic acc;
    logic last;
    logic fin;

    assign loaded = (state_q == ST_ACTIVE);
    assign acc    = loaded & m_ready;
    assign last   = (idx_q == LAST_IDX);
    assign fin    = acc & last;

    // Pop on an idle holder or in the same cycle the final beat is taken; flush and reset block it.
    assign fifo_rden = rstn & ~flush & ~fifo_empty & (~loaded | fin);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
            word_q  <= '0;
            idx_q   <= '0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
        end else if (fifo_rden) begin
            state_q <= ST_ACTIVE;
            word_q  <= fifo_rddata;
            idx_q   <= '0;
        end else if (fin) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
        end else if (acc) begin
            idx_q   <= idx_q + 1'b1;
        end
    end

    beat_slice_mux #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_slice_mux (
        .word (word_q),
        .idx  (idx_q),
        .data (m_data)
    );

    assign m_valid = loaded;
    assign m_last  = loaded & last;
    assign busy    = loaded;

endmodule
